// File: rtl/tybec_axis_pkg.sv
// Shared definitions for the TyBEC AXI-stream adapters.
//   TY_GVECT      : vectorisation factor of the generated `main` pipeline.
//   TY_DATA_WIDTH : width of one packed vector word (32 bits per lane).
//   ty_word_t     : one packed vector word at the default width.
//   ty_ptr_width  : index width for a table of `depth` entries (never below 1).
package tybec_axis_pkg;

  localparam int unsigned TY_GVECT      = 1;
  localparam int unsigned TY_DATA_WIDTH = 32 * TY_GVECT;

  typedef logic [TY_DATA_WIDTH-1:0] ty_word_t;

  function automatic int unsigned ty_ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/tybec_sync_fifo.sv
// Single-clock FIFO with a registered write-ready.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   wvalid_i      : write request; accepted only while wready_o is high
//   wdata_i       : write data
//   wready_o      : registered "not full after this cycle"; low in reset
//   pop_i         : consume the head entry (ignored while empty)
//   rdata_o       : head entry (storage at the read pointer)
//   count_o       : current occupancy, 0..Depth
// Depth must be a power of two, at least 2, so the pointers wrap naturally.
module tybec_sync_fifo
  import tybec_axis_pkg::*;
#(
  parameter int unsigned Width = TY_DATA_WIDTH,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wvalid_i,
  input  logic [Width-1:0]         wdata_i,
  output logic                     wready_o,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = ty_ptr_width(Depth);
  localparam int unsigned CntW = $clog2(Depth) + 1;

  logic [Width-1:0] mem_q [Depth];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            wready_q, wready_d;

  logic push;
  logic pop;

  // Registered ready bounds occupancy: a push is only possible when the
  // previous cycle already guaranteed a free slot.
  assign push = wvalid_i & wready_q;
  assign pop  = pop_i & (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    wready_d = (count_d < CntW'(Depth));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wready_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wready_q <= wready_d;
    end
  end

  // Storage is deliberately not reset; count gates every use of it.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign wready_o = wready_q;
  assign rdata_o  = mem_q[rd_ptr_q];
  assign count_o  = count_q;

endmodule

// File: rtl/tybec_axis_fork.sv
// Output-side adapter: buffers the single `main` result stream and broadcasts
// every word to C_NUM_CHANNELS independent AXI-stream master channels.
// Ports:
//   aclk, aresetn : clock, asynchronous active-low reset
//   ivalid, idata : result word from `main`
//   iready        : registered back-pressure to `main` (its oready)
//   m_tvalid      : per-channel valid; drops once that channel took the head
//   m_tdata       : per-channel data, all carrying the FIFO head word
//   m_tready      : per-channel ready
//   m_tlast       : per-channel end-of-packet, only with TY_AXIS_FORK_TLAST_EN
// Optional feature macro: TY_AXIS_FORK_TLAST_EN adds m_tlast and per-channel
// packet counters of C_PKT_LEN words.
module tybec_axis_fork
  import tybec_axis_pkg::*;
#(
  parameter int unsigned C_DATA_WIDTH   = TY_DATA_WIDTH,
  parameter int unsigned C_NUM_CHANNELS = 2,
  parameter int unsigned C_DEPTH        = 4,
  parameter int unsigned C_PKT_LEN      = 256
) (
  input  logic                                         aclk,
  input  logic                                         aresetn,
  input  logic                                         ivalid,
  input  logic [C_DATA_WIDTH-1:0]                      idata,
  output logic                                         iready,
  output logic [C_NUM_CHANNELS-1:0]                    m_tvalid,
  output logic [C_NUM_CHANNELS-1:0][C_DATA_WIDTH-1:0]  m_tdata,
  input  logic [C_NUM_CHANNELS-1:0]                    m_tready
`ifdef TY_AXIS_FORK_TLAST_EN
  ,
  output logic [C_NUM_CHANNELS-1:0]                    m_tlast
`endif
);

  logic [C_DATA_WIDTH-1:0]    head_data;
  logic [$clog2(C_DEPTH):0]   fifo_count;
  logic                       fifo_nonempty;

  logic [C_NUM_CHANNELS-1:0]  done_q, done_d;
  logic [C_NUM_CHANNELS-1:0]  acc;
  logic                       pop;

  tybec_sync_fifo #(
    .Width (C_DATA_WIDTH),
    .Depth (C_DEPTH)
  ) u_fifo (
    .clk_i    (aclk),
    .rst_ni   (aresetn),
    .wvalid_i (ivalid),
    .wdata_i  (idata),
    .wready_o (iready),
    .pop_i    (pop),
    .rdata_o  (head_data),
    .count_o  (fifo_count)
  );

  assign fifo_nonempty = (fifo_count != '0);

  // m_tvalid depends only on state, never on m_tready. The head word only
  // leaves once every channel has either taken it earlier (done) or takes it
  // now (acc), so slow channels never cause a fast channel to miss a word.
  always_comb begin
    m_tvalid = {C_NUM_CHANNELS{fifo_nonempty}} & ~done_q;
    acc      = m_tvalid & m_tready;
    pop      = fifo_nonempty & (&(done_q | acc));
    done_d   = pop ? '0 : (done_q | acc);
    for (int c = 0; c < int'(C_NUM_CHANNELS); c++) begin
      m_tdata[c] = head_data;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      done_q <= '0;
    end else begin
      done_q <= done_d;
    end
  end

`ifdef TY_AXIS_FORK_TLAST_EN
  localparam int unsigned PktW = ty_ptr_width(C_PKT_LEN);
  localparam logic [PktW-1:0] PktLast = PktW'(C_PKT_LEN - 1);

  logic [C_NUM_CHANNELS-1:0][PktW-1:0] pkt_cnt_q, pkt_cnt_d;

  // Each channel counts its own accepted words, so tlast tracks that
  // channel's view of the packet even when channels run out of step.
  always_comb begin
    for (int c = 0; c < int'(C_NUM_CHANNELS); c++) begin
      pkt_cnt_d[c] = pkt_cnt_q[c];
      if (acc[c]) begin
        pkt_cnt_d[c] = (pkt_cnt_q[c] == PktLast) ? '0 : pkt_cnt_q[c] + PktW'(1);
      end
      m_tlast[c] = m_tvalid[c] & (pkt_cnt_q[c] == PktLast);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pkt_cnt_q <= '0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_tybec_axis_fork.sv
// Directed bench for tybec_axis_fork: two channels, depth 4, packet length 4.
module tb_tybec_axis_fork;
  import tybec_axis_pkg::*;

  localparam int unsigned N  = 2;
  localparam int unsigned D  = 4;
  localparam int unsigned PL = 4;

  logic                   aclk    = 1'b0;
  logic                   aresetn = 1'b0;
  logic                   ivalid  = 1'b0;
  ty_word_t               idata   = '0;
  logic                   iready;
  logic [N-1:0]           m_tvalid;
  logic [N-1:0][TY_DATA_WIDTH-1:0] m_tdata;
  logic [N-1:0]           m_tready = '0;
`ifdef TY_AXIS_FORK_TLAST_EN
  logic [N-1:0]           m_tlast;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned prod_next;
  int unsigned acc_cnt [N];
  bit          tlast_chk = 1'b0;
  ty_word_t    q0 [$];
  ty_word_t    q1 [$];

  always #5 aclk = ~aclk;

  tybec_axis_fork #(
    .C_DATA_WIDTH   (TY_DATA_WIDTH),
    .C_NUM_CHANNELS (N),
    .C_DEPTH        (D),
    .C_PKT_LEN      (PL)
  ) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .ivalid   (ivalid),
    .idata    (idata),
    .iready   (iready),
    .m_tvalid (m_tvalid),
    .m_tdata  (m_tdata),
    .m_tready (m_tready)
`ifdef TY_AXIS_FORK_TLAST_EN
    ,
    .m_tlast  (m_tlast)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    aresetn  = 1'b0;
    ivalid   = 1'b0;
    m_tready = '0;
    step();
    aresetn  = 1'b1;
    step();
    for (int c = 0; c < int'(N); c++) acc_cnt[c] = 0;
  endtask

  // Producer pushes prod_next..prod_last honouring iready; sink records every
  // per-channel accept. mode 0: all ready, 1: channel 1 stalls every other
  // cycle, 2: no ready. Runs until n_out words per channel or budget cycles.
  task automatic run(input int unsigned prod_last, input int unsigned n_out,
                     input int mode, input int unsigned budget);
    int unsigned cyc = 0;
    while (cyc < budget && !(n_out != 0 && q0.size() >= n_out && q1.size() >= n_out)) begin
      case (mode)
        0:       m_tready = 2'b11;
        1:       m_tready = {logic'(cyc[0]), 1'b1};
        default: m_tready = 2'b00;
      endcase
      ivalid = (prod_next <= prod_last);
      idata  = ty_word_t'(prod_next);
      for (int c = 0; c < int'(N); c++) begin
        if (m_tvalid[c] && m_tready[c]) begin
          if (c == 0) q0.push_back(m_tdata[c]);
          else        q1.push_back(m_tdata[c]);
`ifdef TY_AXIS_FORK_TLAST_EN
          if (tlast_chk) begin
            check($sformatf("tlast_ch%0d_w%0d", c, acc_cnt[c]), 64'(m_tlast[c]),
                  64'((acc_cnt[c] % PL) == PL - 1));
          end
`endif
          acc_cnt[c]++;
        end
      end
      if (ivalid && iready) prod_next++;
      step();
      cyc++;
    end
    ivalid   = 1'b0;
    m_tready = '0;
    if (n_out != 0 && cyc >= budget) check("run_timeout", 64'(cyc), 64'(0));
  endtask

  task automatic check_q(input string tag, input int unsigned base, input int unsigned n);
    check({tag, "_n0"}, 64'(q0.size()), 64'(n));
    check({tag, "_n1"}, 64'(q1.size()), 64'(n));
    for (int i = 0; i < int'(n); i++) begin
      if (i < q0.size()) check($sformatf("%s_ch0_%0d", tag, i), 64'(q0[i]), 64'(base + i));
      if (i < q1.size()) check($sformatf("%s_ch1_%0d", tag, i), 64'(q1[i]), 64'(base + i));
    end
    q0.delete();
    q1.delete();
  endtask

  initial begin
    for (int c = 0; c < int'(N); c++) acc_cnt[c] = 0;

    // Reset state and first transfers.
    #2;
    check("rst_iready", 64'(iready), 64'(0));
    check("rst_tvalid", 64'(m_tvalid), 64'(0));
    check("rst_count", 64'(dut.u_fifo.count_q), 64'(0));
    step();
    aresetn = 1'b1;
    check("iready_before_edge", 64'(iready), 64'(0));
    step();
    check("iready_after_edge", 64'(iready), 64'(1));
    ivalid = 1'b1; idata = 32'hA; m_tready = 2'b11;
    step();
    check("t1_tvalid_a", 64'(m_tvalid), 64'(2'b11));
    check("t1_d0_a", 64'(m_tdata[0]), 64'hA);
    check("t1_d1_a", 64'(m_tdata[1]), 64'hA);
    idata = 32'hB;
    step();
    check("t1_tvalid_b", 64'(m_tvalid), 64'(2'b11));
    check("t1_d0_b", 64'(m_tdata[0]), 64'hB);
    check("t1_d1_b", 64'(m_tdata[1]), 64'hB);
    ivalid = 1'b0;
    step();
    check("t1_count_end", 64'(dut.u_fifo.count_q), 64'(0));
    check("t1_tvalid_end", 64'(m_tvalid), 64'(0));

    // Channel 1 slow: channel 0 takes the word, channel 1 holds it.
    m_tready = 2'b01; ivalid = 1'b1; idata = 32'h1;
    step();
    check("t2_tvalid_1", 64'(m_tvalid), 64'(2'b11));
    idata = 32'h2;
    step();
    check("t2_tvalid_ch0_done", 64'(m_tvalid), 64'(2'b10));
    check("t2_d1_hold", 64'(m_tdata[1]), 64'h1);
    ivalid = 1'b0;
    step();
    check("t2_tvalid_still", 64'(m_tvalid), 64'(2'b10));
    check("t2_d1_stable", 64'(m_tdata[1]), 64'h1);
    m_tready = 2'b11;
    step();
    check("t2_tvalid_2", 64'(m_tvalid), 64'(2'b11));
    check("t2_d0_2", 64'(m_tdata[0]), 64'h2);
    check("t2_d1_2", 64'(m_tdata[1]), 64'h2);
    step();
    check("t2_count_end", 64'(dut.u_fifo.count_q), 64'(0));
    m_tready = '0;

    // Fill with no ready: exactly D words taken, then drain in order.
    prod_next = 1;
    run(6, 0, 2, 6);
    check("t3_accepted", 64'(prod_next - 1), 64'(D));
    check("t3_iready_full", 64'(iready), 64'(0));
    check("t3_count_full", 64'(dut.u_fifo.count_q), 64'(D));
    check("t3_tvalid_full", 64'(m_tvalid), 64'(2'b11));
    m_tready = 2'b11; ivalid = 1'b1; idata = ty_word_t'(prod_next);
    q0.push_back(m_tdata[0]);
    q1.push_back(m_tdata[1]);
    if (iready) prod_next++;
    step();
    check("t3_iready_back", 64'(iready), 64'(1));
    run(6, 6, 0, 30);
    check_q("t3_order", 1, 6);
    check("t3_count_end", 64'(dut.u_fifo.count_q), 64'(0));

    // Full-rate stream: push and pop together keep count at 1.
    m_tready = 2'b11; ivalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idata = ty_word_t'(32'h10 + i);
      step();
      check($sformatf("t4_count_%0d", i), 64'(dut.u_fifo.count_q), 64'(1));
      check($sformatf("t4_data_%0d", i), 64'(m_tdata[1]), 64'(32'h10 + i));
    end
    ivalid = 1'b0;
    step();
    check("t4_count_end", 64'(dut.u_fifo.count_q), 64'(0));
    m_tready = '0;
    prod_next = 32'h20;
    run(32'h27, 8, 1, 60);
    check_q("t4_stall_order", 32'h20, 8);

    // Reset mid-stream discards buffered words.
    m_tready = 2'b00; ivalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idata = ty_word_t'(32'h31 + i);
      step();
    end
    ivalid = 1'b0;
    check("t5_count_3", 64'(dut.u_fifo.count_q), 64'(3));
    aresetn = 1'b0;
    #1;
    check("t5_rst_tvalid", 64'(m_tvalid), 64'(0));
    check("t5_rst_iready", 64'(iready), 64'(0));
    check("t5_rst_count", 64'(dut.u_fifo.count_q), 64'(0));
    step();
    aresetn = 1'b1;
    step();
    check("t5_iready", 64'(iready), 64'(1));
    ivalid = 1'b1; idata = 32'h55; m_tready = 2'b11;
    step();
    check("t5_tvalid_55", 64'(m_tvalid), 64'(2'b11));
    check("t5_d0_55", 64'(m_tdata[0]), 64'h55);
    check("t5_d1_55", 64'(m_tdata[1]), 64'h55);
    ivalid = 1'b0;
    step();
    m_tready = '0;

    // Packet stream with staggered channels; tlast checked where enabled.
    do_reset();
    tlast_chk = 1'b1;
    prod_next = 32'h40;
    run(32'h47, 8, 1, 60);
    tlast_chk = 1'b0;
    check_q("t6_order", 32'h40, 8);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
